mc_sequencer: RTL and testbench

MC_SEQUENCER -- requirements
Module: mc_sequencer

---
 rtl/mc_pkg.sv | 34 +++
 rtl/perf_counter.sv | 19 +
 rtl/mc_sequencer.sv | 133 +++++++++++++
 tb/tb_mc_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle sequencer: FSM state encoding, RV32I major
// opcodes and small opcode classifiers used during EXEC routing.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic is_jump(input logic [6:0] opc);
        return (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

    // Opcodes that finish with a register-file write and no memory access.
    function automatic logic is_wb_only(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LUI) ||
               (opc == OPC_AUIPC) || is_jump(opc);
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running wrap-around event counter with asynchronous clear.
module perf_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I control sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, owns pc and ir, and keeps cycle/instret counters.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0,
    parameter int              CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic [XLEN-1:0]  alu_out,
    input  logic             br_taken,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  ir,
    output logic             rf_en,
    output logic             trap,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_t          state;
    logic [6:0]      opcode;
    logic [XLEN-1:0] target;
    logic            redirect;
    logic            misaligned;
    logic            retire;

    assign opcode = ir[6:0];
    assign target = alu_out & ~XLEN'(1);

    // Retire marks every transition back into FETCH; it both steps pc and
    // counts the instruction, so a faulting redirect never does either.
    always_comb begin
        redirect   = is_jump(opcode) || ((opcode == OPC_BRANCH) && br_taken);
        misaligned = redirect && target[1];
        retire     = 1'b0;
        case (state)
            S_EXEC:  retire = (opcode == OPC_BRANCH) && !misaligned;
            S_MEM:   retire = dmem_ack && (opcode == OPC_STORE);
            S_WB:    retire = !misaligned;
            default: retire = 1'b0;
        endcase
    end

    // Fetch request is decoded combinationally so it is live in the very
    // first cycle after reset and vanishes the instant reset asserts.
    assign imem_req = (state == S_FETCH) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            rf_en    <= 1'b0;
            trap     <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
                        state    <= S_MEM;
                        dmem_req <= 1'b1;
                        dmem_we  <= (opcode == OPC_STORE);
                    end else if (opcode == OPC_BRANCH) begin
                        state <= misaligned ? S_TRAP : S_FETCH;
                        trap  <= misaligned;
                    end else if (is_wb_only(opcode)) begin
                        state <= S_WB;
                        rf_en <= 1'b1;
                    end else begin
                        state <= S_TRAP;
                        trap  <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (opcode == OPC_STORE) begin
                            state <= S_FETCH;
                        end else begin
                            state <= S_WB;
                            rf_en <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    rf_en <= 1'b0;
                    state <= misaligned ? S_TRAP : S_FETCH;
                    trap  <= misaligned;
                end
                default: begin
                    state <= S_TRAP;
                    trap  <= 1'b1;
                end
            endcase

            if (retire) begin
                pc <= redirect ? target : pc + XLEN'(4);
            end
        end
    end

    perf_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (state != S_TRAP),
        .count (cycle_cnt)
    );

    perf_counter #(.W(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .count (instret_cnt)
    );

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized self-checking bench for mc_sequencer, compared per instruction
// against a transaction-level model (latency, pc, counters, strobes).
module tb_mc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic [31:0] alu_out = '0;
    logic        br_taken = 1'b0;

    logic        imem_req, dmem_req, dmem_we, rf_en, trap;
    logic [31:0] pc, ir;
    logic [63:0] cycle_cnt, instret_cnt;

    logic        imem_req4, dmem_req4, dmem_we4, rf_en4, trap4;
    logic [31:0] pc4, ir4;
    logic [3:0]  cycle_cnt4, instret_cnt4;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    logic [63:0] m_cycle, m_instret;

    mc_sequencer dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .alu_out(alu_out), .br_taken(br_taken),
        .pc(pc), .ir(ir), .rf_en(rf_en), .trap(trap),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    // Narrow-counter twin driven in lockstep to observe counter wrap.
    mc_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .imem_req(imem_req4), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .dmem_req(dmem_req4), .dmem_we(dmem_we4),
        .dmem_ack(dmem_ack), .alu_out(alu_out), .br_taken(br_taken),
        .pc(pc4), .ir(ir4), .rf_en(rf_en4), .trap(trap4),
        .cycle_cnt(cycle_cnt4), .instret_cnt(instret_cnt4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit isLegal(input logic [6:0] o);
        return o inside {7'h03, 7'h23, 7'h63, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67};
    endfunction

    task automatic doReset();
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_ir", ir, 32'h0);
        checkOutput("rst_cycle", cycle_cnt, 0);
        checkOutput("rst_instret", instret_cnt, 0);
        checkOutput("rst_strobes", {imem_req, dmem_req, dmem_we, rf_en, trap}, 5'b0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_imem_req", imem_req, 1'b1);
        m_pc = 32'h0;
        m_cycle = 0;
        m_instret = 0;
    endtask

    // Plays memory for one instruction and measures what the DUT did.
    task automatic applyStimulus(input logic [31:0] instr, input bit taken, input logic [31:0] alu,
                                 input int fd, input int md, output int cyc, output int rfc,
                                 output int dmc, output bit we_seen, output bit trapped);
        bit fetched = 0;
        bit done = 0;
        int wf = 0;
        int wm = 0;
        cyc = 0; rfc = 0; dmc = 0; we_seen = 0; trapped = 0;
        br_taken = taken;
        alu_out = alu;
        while (!done) begin
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (cyc >= 60) begin
                checkOutput("watchdog", 1'b1, 1'b0);
                done = 1;
            end else if (trap) begin
                trapped = 1;
                done = 1;
            end else if (imem_req && fetched) begin
                done = 1;
            end else begin
                cyc++;
                if (rf_en) rfc++;
                if (imem_req) begin
                    if (wf == fd) begin
                        imem_ack = 1'b1;
                        imem_rdata = instr;
                        fetched = 1;
                    end else begin
                        wf++;
                        imem_rdata = $urandom;
                    end
                end else begin
                    imem_ack = ($urandom_range(0, 3) == 0);
                end
                if (dmem_req) begin
                    dmc++;
                    if (dmem_we) we_seen = 1;
                    if (wm == md) dmem_ack = 1'b1;
                    else wm++;
                end else begin
                    dmem_ack = ($urandom_range(0, 3) == 0);
                end
                @(negedge clk);
            end
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic runOne(input logic [31:0] instr, input bit taken, input logic [31:0] alu,
                          input int fd, input int md);
        logic [6:0]  opc = instr[6:0];
        bit is_ld  = (opc == 7'h03);
        bit is_st  = (opc == 7'h23);
        bit is_br  = (opc == 7'h63);
        bit is_jmp = (opc == 7'h6f) || (opc == 7'h67);
        bit is_alu = opc inside {7'h33, 7'h13, 7'h37, 7'h17};
        logic [31:0] tgt = {alu[31:1], 1'b0};
        bit redir = is_jmp || (is_br && taken);
        bit e_trap = !isLegal(opc) || (redir && tgt[1]);
        int e_cyc = fd + 3 + ((is_ld || is_st) ? md + 1 : 0) + ((is_ld || is_alu || is_jmp) ? 1 : 0);
        int e_rf  = (is_ld || is_alu || is_jmp) ? 1 : 0;
        int e_dm  = (is_ld || is_st) ? md + 1 : 0;
        int cyc, rfc, dmc;
        bit we_seen, trapped;
        bit noisy = 0;

        if (!e_trap) m_pc = redir ? tgt : m_pc + 32'd4;
        m_cycle += 64'(e_cyc);
        if (!e_trap) m_instret++;

        applyStimulus(instr, taken, alu, fd, md, cyc, rfc, dmc, we_seen, trapped);
        checkOutput("latency", cyc, e_cyc);
        checkOutput("trap_flag", trapped, e_trap);
        checkOutput("ir", ir, instr);
        checkOutput("pc", pc, m_pc);
        checkOutput("instret", instret_cnt, m_instret);
        checkOutput("cycle", cycle_cnt, m_cycle);
        checkOutput("instret4", instret_cnt4, m_instret[3:0]);
        checkOutput("cycle4", cycle_cnt4, m_cycle[3:0]);
        if (rfc != e_rf) checkOutput("rf_en_pulses", rfc, e_rf);
        if (dmc != e_dm) checkOutput("dmem_req_cycles", dmc, e_dm);
        if (we_seen != is_st) checkOutput("dmem_we", we_seen, is_st);

        if (trapped) begin
            repeat (20) begin
                imem_ack = $urandom_range(0, 1);
                dmem_ack = $urandom_range(0, 1);
                @(negedge clk);
                if (imem_req || dmem_req || rf_en || !trap) noisy = 1;
            end
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            checkOutput("trap_quiet", noisy, 1'b0);
            checkOutput("trap_cycle_frozen", cycle_cnt, m_cycle);
            checkOutput("trap_instret_frozen", instret_cnt, m_instret);
            checkOutput("trap_pc_held", pc, m_pc);
            doReset();
        end
    endtask

    initial begin
        logic [6:0]  legal_ops [9] = '{7'h03, 7'h23, 7'h63, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67};
        logic [31:0] instr;
        logic [31:0] alu;
        logic [6:0]  o;

        doReset();
        $display("[TB] directed instructions");
        runOne(32'h00500093, 1'b0, 32'h0, 0, 0);
        runOne(32'h0000a103, 1'b0, 32'h100, 0, 3);
        runOne(32'h00000063, 1'b1, 32'h40, 0, 0);
        runOne(32'h00000063, 1'b1, 32'h42, 0, 0);
        runOne(32'hffffffff, 1'b0, 32'h0, 0, 0);
        runOne(32'h0000006f, 1'b0, 32'hfffffffc, 1, 0);
        runOne(32'h00500093, 1'b0, 32'h0, 0, 0);
        runOne(32'h0020a023, 1'b0, 32'h80, 2, 1);

        $display("[TB] reset during data access");
        runOne(32'h00500093, 1'b0, 32'h0, 0, 0);
        imem_rdata = 32'h0000a103;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("mid_mem_dmem_req", dmem_req, 1'b1);
        dmem_ack = 1'b1;
        rst = 1'b1;
        #1;
        checkOutput("rst_drops_dmem_req", dmem_req, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dmem_ack = 1'b0;
        #1;
        checkOutput("mid_rst_pc", pc, 32'h0);
        checkOutput("mid_rst_instret", instret_cnt, 0);
        checkOutput("mid_rst_imem_req", imem_req, 1'b1);
        checkOutput("mid_rst_rf_en", rf_en, 1'b0);
        m_pc = 32'h0;
        m_cycle = 0;
        m_instret = 0;

        $display("[TB] sixteen retirements for narrow counter wrap");
        repeat (16) runOne(32'h00500093, 1'b0, 32'h0, 0, 0);
        checkOutput("instret_wide_16", instret_cnt, 64'd16);
        checkOutput("instret4_wrap", instret_cnt4, 4'd0);

        $display("[TB] random instruction stream");
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                do o = 7'($urandom); while (isLegal(o));
            end else begin
                o = legal_ops[$urandom_range(0, 8)];
            end
            instr = $urandom;
            instr[6:0] = o;
            alu = $urandom;
            if ($urandom_range(0, 7) != 0) alu[1] = 1'b0;
            runOne(instr, 1'($urandom_range(0, 1)), alu, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
